// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with mid-bit sampling, start-bit glitch rejection,
// framing/overrun detection and a first-word-fall-through receive FIFO drained
// through a valid (empty=0) / rd_en handshake.
// Optional feature: define UART_PARITY_EN to add one parity bit per frame,
// the PARITY_ODD parameter and the parity_err output.
module uart_rx_fifo #(
   parameter int BAUD_DIV  = 2604,
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 32
`ifdef UART_PARITY_EN
   ,
   parameter int PARITY_ODD = 0
`endif
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         RX,
   input  logic                         En,
   input  logic                         rd_en,
   output logic [DATA_BITS-1:0]         data_out,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         frame_err,
   output logic                         overrun,
   output logic                         busy
`ifdef UART_PARITY_EN
   ,
   output logic                         parity_err
`endif
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   // Start state samples half a bit in so every later sample lands mid-bit.
   localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(BAUD_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   logic                 rx_meta, rx_s, rx_prev;
   logic                 rx_fall;
   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 push_req;
   logic [DATA_BITS-1:0] push_data;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic                 pop, do_push;
`ifdef UART_PARITY_EN
   logic                 par_bit;
   logic                 par_ok;

   assign par_ok = (((^shift) ^ par_bit) == (PARITY_ODD != 0));
`endif

   assign rx_fall = rx_prev & ~rx_s;

   // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high preset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         rx_meta <= RX;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Receive FSM: bit timer, shift register, registered pulses and push request.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         push_req  <= 1'b0;
         push_data <= '0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         push_req  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err <= 1'b0;
`endif
         cnt <= cnt + CNT_W'(1);
         if (!En && state != S_IDLE) begin
            // Receiver disabled mid-frame: drop everything silently.
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  cnt <= '0;
                  if (En && rx_fall) begin
                     state <= S_START;
                     busy  <= 1'b1;
                  end
               end
               S_START: begin
                  if (cnt == HALF_TERM) begin
                     cnt <= '0;
                     if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                     end
                  end
               end
               S_DATA: begin
                  if (cnt == FULL_TERM) begin
                     cnt            <= '0;
                     shift[bit_idx] <= rx_s;
                     if (bit_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                     end
                  end
               end
`ifdef UART_PARITY_EN
               S_PARITY: begin
                  if (cnt == FULL_TERM) begin
                     cnt     <= '0;
                     par_bit <= rx_s;
                     state   <= S_STOP;
                  end
               end
`endif
               S_STOP: begin
                  if (cnt == FULL_TERM) begin
                     cnt <= '0;
                     if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
`ifdef UART_PARITY_EN
                        if (par_ok) begin
                           push_req  <= 1'b1;
                           push_data <= shift;
                        end else begin
                           parity_err <= 1'b1;
                        end
`else
                        push_req  <= 1'b1;
                        push_data <= shift;
`endif
                     end else begin
                        frame_err <= 1'b1;
                        state     <= S_BREAK;
                     end
                  end
               end
               S_BREAK: begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign empty    = (count == '0);
   assign full     = (count == FULL_OCC);
   assign pop      = rd_en & ~empty;
   assign do_push  = push_req & (~full | pop);
   assign data_out = empty ? '0 : mem[rd_ptr];

   // FIFO storage write port.
   always_ff @(posedge Clk) begin
      // NOTE: storage is not reset; occupancy is, and data_out is masked while empty.
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // FIFO pointers, occupancy and overrun pulse.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push_req & full & ~pop;
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !pop)      count <= count + OCC_W'(1);
         else if (!do_push && pop) count <= count - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with BAUD_DIV=16, DATA_BITS=8, DEPTH=4.
// Define UART_PARITY_EN to also exercise the parity option (even parity).
module tb_uart_rx_fifo;

   localparam int BAUD_DIV  = 16;
   localparam int DATA_BITS = 8;
   localparam int DEPTH     = 4;
`ifdef UART_PARITY_EN
   localparam int PAR_CYC = BAUD_DIV;
`else
   localparam int PAR_CYC = 0;
`endif
   // Edges from the RX falling edge to the start of the push cycle:
   // 3 (sync + edge) + 8 (half bit) + 8*16 (data) + parity + 16 (stop).
   localparam int PUSH_LAT = 155 + PAR_CYC;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       rx;
   logic       En;
   logic       rd_en;
   logic [7:0] data_out;
   logic       empty, full;
   logic [2:0] count;
   logic       frame_err, overrun, busy;
`ifdef UART_PARITY_EN
   logic       parity_err;
`endif

   uart_rx_fifo #(
      .BAUD_DIV  (BAUD_DIV),
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .RX        (rx),
      .En        (En),
      .rd_en     (rd_en),
      .data_out  (data_out),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
`ifdef UART_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   always #5 Clk = ~Clk;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, both_cnt = 0;
   int   fall_cyc = -1;
   logic empty_q = 1'b1;

   always @(posedge Clk) cyc++;

   // Pulse counters and empty-fall timestamp, sampled away from the active edge.
   always @(negedge Clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
`ifdef UART_PARITY_EN
      if (parity_err === 1'b1) pe_cnt++;
`endif
      if (empty_q === 1'b1 && empty === 1'b0) fall_cyc = cyc;
      empty_q = empty;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Drive one frame; the line is left at the stop-bit level afterwards.
   task automatic send_bits(input logic [7:0] d, input logic par, input logic stop_bit);
      rx = 1'b0;
      wait_cycles(BAUD_DIV);
      for (int i = 0; i < DATA_BITS; i++) begin
         rx = d[i];
         wait_cycles(BAUD_DIV);
      end
`ifdef UART_PARITY_EN
      rx = par;
      wait_cycles(BAUD_DIV);
`else
      rx = par | 1'b1;
`endif
      rx = stop_bit;
      wait_cycles(BAUD_DIV);
   endtask

   // Frame with correct (even) parity when parity is built in.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_bits(d, ^d, stop_bit);
   endtask

   task automatic read_expect(input string tag, input logic [7:0] exp);
      check(tag, {24'd0, data_out}, {24'd0, exp});
      rd_en = 1'b1;
      wait_cycles(1);
      rd_en = 1'b0;
   endtask

   initial begin
      Reset = 1'b0;
      rx    = 1'b1;
      En    = 1'b1;
      rd_en = 1'b0;
      #1 Reset = 1'b1;
      wait_cycles(3);

      // Reset values
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      Reset = 1'b0;
      wait_cycles(5);

      // 1: good frame 0xA5, latency of empty fall, then pop
      begin
         int start_cyc;
         int lat;
         start_cyc = cyc;
         send_frame(8'hA5, 1'b1);
         wait_cycles(4);
         lat = fall_cyc - start_cyc;
         check("t1_latency_window", {31'd0, (lat >= 150 + PAR_CYC) && (lat <= 160 + PAR_CYC)}, 32'd1);
         check("t1_empty", {31'd0, empty}, 32'd0);
         check("t1_count", {29'd0, count}, 32'd1);
         read_expect("t1_data", 8'hA5);
         check("t1_empty_after_pop", {31'd0, empty}, 32'd1);
         check("t1_ferr_none", fe_cnt, 32'd0);
      end

      // 2: 5-cycle glitch on RX is rejected
      rx = 1'b0;
      wait_cycles(5);
      check("t2_busy_in_start", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_cycles(20);
      check("t2_busy_fell", {31'd0, busy}, 32'd0);
      check("t2_count", {29'd0, count}, 32'd0);
      check("t2_ferr_none", fe_cnt, 32'd0);

      // 3: bad stop bit, held-low break, then recovery
      send_frame(8'h3C, 1'b0);
      wait_cycles(40);
      check("t3_ferr_pulse", fe_cnt, 32'd1);
      check("t3_count", {29'd0, count}, 32'd0);
      check("t3_busy_in_break", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_cycles(10);
      check("t3_busy_idle", {31'd0, busy}, 32'd0);
      send_frame(8'h11, 1'b1);
      wait_cycles(4);
      check("t3_count_after", {29'd0, count}, 32'd1);
      read_expect("t3_data", 8'h11);

      // 4: five frames without reads -> overrun on the fifth
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1);
         wait_cycles(2);
      end
      check("t4_count", {29'd0, count}, 32'd4);
      check("t4_full", {31'd0, full}, 32'd1);
      check("t4_ovr_pulse", ov_cnt, 32'd1);
      read_expect("t4_rd0", 8'h01);
      read_expect("t4_rd1", 8'h02);
      read_expect("t4_rd2", 8'h03);
      read_expect("t4_rd3", 8'h04);
      check("t4_empty", {31'd0, empty}, 32'd1);

      // 5: simultaneous pop and push while full
      for (int i = 0; i < 4; i++) begin
         send_frame(8'h21 + 8'(i), 1'b1);
         wait_cycles(2);
      end
      check("t5_full", {31'd0, full}, 32'd1);
      fork
         send_frame(8'h77, 1'b1);
         begin
            wait_cycles(PUSH_LAT);
            rd_en = 1'b1;
            wait_cycles(1);
            rd_en = 1'b0;
         end
      join
      wait_cycles(2);
      check("t5_count", {29'd0, count}, 32'd4);
      check("t5_no_ovr", ov_cnt, 32'd1);
      read_expect("t5_rd0", 8'h22);
      read_expect("t5_rd1", 8'h23);
      read_expect("t5_rd2", 8'h24);
      read_expect("t5_rd3", 8'h77);

      // rd_en while empty has no effect
      rd_en = 1'b1;
      wait_cycles(2);
      rd_en = 1'b0;
      check("t5_rd_empty_count", {29'd0, count}, 32'd0);

      // 6: reset mid-frame flushes the FIFO and aborts the frame
      send_frame(8'h99, 1'b1);
      wait_cycles(2);
      check("t6_pre_count", {29'd0, count}, 32'd1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            wait_cycles(60);
            Reset = 1'b1;
            #1;
            check("t6_rst_busy", {31'd0, busy}, 32'd0);
            check("t6_rst_empty", {31'd0, empty}, 32'd1);
            check("t6_rst_count", {29'd0, count}, 32'd0);
            check("t6_rst_data", {24'd0, data_out}, 32'd0);
            wait_cycles(2);
            Reset = 1'b0;
         end
      join
      wait_cycles(4);
      check("t6_no_partial", {29'd0, count}, 32'd0);
      send_frame(8'h42, 1'b1);
      wait_cycles(4);
      check("t6_count", {29'd0, count}, 32'd1);
      read_expect("t6_data", 8'h42);

`ifdef UART_PARITY_EN
      // 7: even parity, 0x07 needs parity bit 1
      send_bits(8'h07, 1'b0, 1'b1);
      wait_cycles(4);
      check("t7_perr_pulse", pe_cnt, 32'd1);
      check("t7_not_pushed", {29'd0, count}, 32'd0);
      send_bits(8'h07, 1'b1, 1'b1);
      wait_cycles(4);
      check("t7_perr_unchanged", pe_cnt, 32'd1);
      check("t7_count", {29'd0, count}, 32'd1);
      read_expect("t7_data", 8'h07);
`endif

      check("ferr_total", fe_cnt, 32'd1);
      check("never_both", both_cnt, 32'd0);
      check("perr_total", pe_cnt, PAR_CYC != 0 ? 32'd1 : 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
